// File: rtl/writeback_queue.sv
// In-order writeback queue between the writeback arbiter and the register file write port,
// with a combinational pending-value lookup. Optional feature: `define WBQ_COALESCE_EN.
module writeback_queue #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int QDEPTH    = 8,
  parameter int DROP_ZERO = 1,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int PTR_W      = $clog2(QDEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  // Handshake: a result transfers on a rising edge where in_valid && in_ready; the
  // producer holds in_addr/in_data stable while in_valid is high and in_ready is low.
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  input  logic                  stall,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic                  hit,
  output logic [WIDTH-1:0]      hit_data,
  output logic [CNT_W-1:0]      count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

  logic [ADDR_WIDTH-1:0] addr_q [QDEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [QDEPTH];
  logic [WIDTH-1:0]      data_q [QDEPTH];
  logic [WIDTH-1:0]      data_d [QDEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;

  logic                  pop, drop, accept, alloc;
  logic [PTR_W-1:0]      idx;
  logic                  coal_hit;
  logic [PTR_W-1:0]      coal_idx;

  assign pop  = (count_q != '0) && !stall;
  assign drop = (DROP_ZERO != 0) && (in_addr == '0);

  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    coal_hit = 1'b0;
    coal_idx = '0;
    idx      = '0;
    for (int k = 0; k < QDEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (CNT_W'(k) < count_q) begin
        if (addr_q[idx] == raddr) begin
          hit      = 1'b1;
          hit_data = data_q[idx];
        end
        if ((addr_q[idx] == in_addr) && !(pop && (k == 0))) begin
          coal_hit = 1'b1;
          coal_idx = idx;
        end
      end
    end
  end

`ifdef WBQ_COALESCE_EN
  assign in_ready = (count_q < FULL) || coal_hit;
  assign alloc    = accept && !drop && !coal_hit;
`else
  assign in_ready = (count_q < FULL);
  assign alloc    = accept && !drop;
`endif
  assign accept = in_valid && in_ready;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = pop ? head_q + PTR_W'(1) : head_q;
    tail_d  = alloc ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    wen_d   = pop;
    waddr_d = pop ? addr_q[head_q] : waddr_q;
    wdata_d = pop ? data_q[head_q] : wdata_q;
    if (alloc) begin
      addr_d[tail_q] = in_addr;
      data_d[tail_q] = in_data;
    end
`ifdef WBQ_COALESCE_EN
    if (accept && !drop && coal_hit) data_d[coal_idx] = in_data;
`endif
    if (alloc && !pop)      count_d = count_q + CNT_W'(1);
    else if (!alloc && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign count = count_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Randomized and directed bench for writeback_queue against a queue-based reference model.
module tb_writeback_queue;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int QD = 8;
  localparam int CW = 4;

  logic          clk, reset;
  logic          in_valid, in_ready, stall, wen, hit;
  logic [AW-1:0] in_addr, waddr, raddr;
  logic [W-1:0]  in_data, wdata, hit_data;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  // Model: pending entries packed as {addr, data}, oldest first.
  logic [AW+W-1:0] exp_q[$];
  logic            exp_wen;
  logic [AW-1:0]   exp_waddr;
  logic [W-1:0]    exp_wdata;

  writeback_queue dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
    .stall(stall), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .hit(hit), .hit_data(hit_data), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after an edge, check lookup/ready/count, step the model,
  // cross the edge and check the registered write port.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [W-1:0] d,
                      input logic st, input logic [AW-1:0] ra);
    int sz, lo, ci;
    logic ready, do_pop, mhit;
    logic [W-1:0] mdata;
    logic [AW+W-1:0] e;
    in_valid = v; in_addr = a; in_data = d; stall = st; raddr = ra;
    #1;
    sz = exp_q.size();
    do_pop = (sz != 0) && !st;
    lo = do_pop ? 1 : 0;
    ci = -1; mhit = 1'b0; mdata = '0;
    for (int i = 0; i < sz; i++) begin
      e = exp_q[i];
      if (e[AW+W-1:W] == ra) begin mhit = 1'b1; mdata = e[W-1:0]; end
      if (i >= lo && e[AW+W-1:W] == a) ci = i;
    end
`ifdef WBQ_COALESCE_EN
    ready = (sz < QD) || (ci >= 0);
`else
    ready = (sz < QD);
`endif
    check("in_ready", in_ready, ready);
    check("count", count, sz);
    check("hit", hit, mhit);
    check("hit_data", hit_data, mdata);
    if (do_pop) begin
      e = exp_q.pop_front();
      exp_wen = 1'b1; exp_waddr = e[AW+W-1:W]; exp_wdata = e[W-1:0];
    end else begin
      exp_wen = 1'b0;
    end
    if (v && ready && a != '0) begin
`ifdef WBQ_COALESCE_EN
      if (ci >= 0) begin
        e = exp_q[ci - lo];
        exp_q[ci - lo] = {e[AW+W-1:W], d};
      end else exp_q.push_back({a, d});
`else
      exp_q.push_back({a, d});
`endif
    end
    @(posedge clk); #1;
    check("wen", wen, exp_wen);
    if (exp_wen) begin
      check("waddr", waddr, exp_waddr);
      check("wdata", wdata, exp_wdata);
    end
  endtask

  task automatic idle(input int n, input logic st);
    repeat (n) step(1'b0, '0, '0, st, '0);
  endtask

  task automatic async_reset(input logic [AW-1:0] ra);
    raddr = ra; in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    exp_wen = 1'b0; exp_waddr = '0; exp_wdata = '0;
    check("rst_wen", wen, 1'b0);
    check("rst_waddr", waddr, '0);
    check("rst_wdata", wdata, '0);
    check("rst_count", count, '0);
    check("rst_hit", hit, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; stall = 1'b0; raddr = '0;
    exp_wen = 1'b0; exp_waddr = '0; exp_wdata = '0;
    @(posedge clk); #1;
    check("init_wen", wen, 1'b0);
    check("init_count", count, '0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Single write latency.
    step(1'b1, 5'd5, 32'hA, 1'b0, 5'd5);
    idle(3, 1'b0);

    // Fill under stall, blocked enqueue, drain in order.
    for (int i = 1; i <= 8; i++) step(1'b1, AW'(i), W'(32'h100 + i), 1'b1, AW'(i));
    step(1'b1, 5'd9, 32'h999, 1'b1, 5'd8);
    idle(10, 1'b0);

    // Youngest-match lookup.
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3);
    step(1'b1, 5'd3, 32'h22, 1'b1, 5'd3);
    step(1'b0, '0, '0, 1'b1, 5'd3);
    step(1'b0, '0, '0, 1'b1, 5'd4);
    idle(4, 1'b0);

    // Zero register is dropped.
    step(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0);
    idle(3, 1'b0);

    // Full queue with a pop in the same cycle does not accept.
    for (int i = 1; i <= 8; i++) step(1'b1, AW'(i + 10), W'(i), 1'b1, 5'd11);
    step(1'b1, 5'd20, 32'h55, 1'b0, 5'd20);
    step(1'b0, '0, '0, 1'b1, 5'd20);
    idle(10, 1'b0);

    // Reset while writing with entries pending.
    for (int i = 1; i <= 6; i++) step(1'b1, AW'(i + 20), W'(i), 1'b1, 5'd22);
    step(1'b0, '0, '0, 1'b0, 5'd22);
    async_reset(5'd23);
    idle(4, 1'b0);

    // Coalescing sequence (plain allocation when the feature is off).
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3);
    step(1'b1, 5'd7, 32'h1, 1'b1, 5'd3);
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd3);
    step(1'b0, '0, '0, 1'b1, 5'd3);
    idle(5, 1'b0);

    // Random traffic over a small address range to provoke hits and merges.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), W'($urandom),
           $urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)));
      if (n == 700) async_reset(AW'($urandom_range(0, 7)));
    end
    idle(12, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
